// File: rtl/instr_loader.sv
// Boot-time program loader: frames a byte stream (count, LE payload, XOR checksum) into
// instruction-memory writes and releases the fetch stage once the program is verified.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  start,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam logic [16:0] Capacity = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    StHdrLo,
    StHdrHi,
    StPayload,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e state_q, state_d;

  logic [15:0]           count_q;
  logic [15:0]           words_q;
  logic [7:0]            csum_q;
  logic [1:0]            idx_q;
  logic [31:0]           buf_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_data_q;
  logic                  imem_wren_q;

  logic        accept;
  logic        last_byte;
  logic        restart;
  logic [15:0] count_full;
  logic [15:0] words_inc;

  assign accept     = byte_valid && byte_ready;
  assign last_byte  = (idx_q == 2'd3);
  assign restart    = ((state_q == StDone) || (state_q == StError)) && reload;
  assign count_full = {byte_data, count_q[7:0]};
  assign words_inc  = words_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StHdrLo;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdrLo: begin
        if (accept) state_d = StHdrHi;
      end
      StHdrHi: begin
        if (accept) begin
          if ({1'b0, count_full} > Capacity) begin
            state_d = StError;
          end else if (count_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (accept && last_byte && (words_inc == count_q)) state_d = StCheck;
      end
      StCheck: begin
        if (accept) state_d = (byte_data == csum_q) ? StDone : StError;
      end
      StDone, StError: begin
        if (reload) state_d = StHdrLo;
      end
      default: state_d = StHdrLo;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    start      = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      StHdrLo:                    byte_ready = 1'b1;
      StHdrHi, StPayload, StCheck: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      StDone:                     start = 1'b1;
      StError:                    error = 1'b1;
      default:                    byte_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      words_q     <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      imem_wren_q <= 1'b0;
    end else begin
      imem_wren_q <= 1'b0;
      if (restart) begin
        words_q <= '0;
        csum_q  <= '0;
        idx_q   <= '0;
      end
      if (accept) begin
        unique case (state_q)
          StHdrLo: count_q[7:0]  <= byte_data;
          StHdrHi: count_q[15:8] <= byte_data;
          StPayload: begin
            csum_q <= csum_q ^ byte_data;
            idx_q  <= idx_q + 2'd1;
            buf_q[{idx_q, 3'b000} +: 8] <= byte_data;
            // Byte 3 completes the word: write it straight from the bus plus the held bytes.
            if (last_byte) begin
              imem_wren_q <= 1'b1;
              imem_addr_q <= words_q[ADDR_WIDTH-1:0];
              imem_data_q <= {byte_data, buf_q[23:0]};
              words_q     <= words_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr    = imem_addr_q;
  assign imem_data    = imem_data_q;
  assign imem_wren    = imem_wren_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader: a frame-level model predicts every write,
// its cycle, and the final load outcome; a per-cycle process compares the DUT against it.
module tb_instr_loader;

  localparam int AW  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          reload = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_wren;
  logic          start;
  logic          busy;
  logic          error;
  logic [15:0]   words_loaded;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .reload       (reload),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .imem_wren    (imem_wren),
    .start        (start),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          log_cyc[$];
  int          log_addr[$];
  logic [31:0] log_data[$];

  // Every cycle: a write appears exactly when predicted, and ready agrees with the end flags.
  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("wren", 32'(imem_wren), 32'd1);
        check("wr_addr", 32'(imem_addr), 32'(exp_q[0].addr));
        check("wr_data", imem_data, exp_q[0].data);
        check("words_at_wr", 32'(words_loaded), 32'(exp_q[0].addr + 1));
        void'(exp_q.pop_front());
      end else begin
        check("no_wren", 32'(imem_wren), 32'd0);
      end
      if (imem_wren) begin
        log_cyc.push_back(cyc);
        log_addr.push_back(int'(imem_addr));
        log_data.push_back(imem_data);
      end
      check("start_error_excl", 32'(start && error), 32'd0);
      check("ready_vs_end", 32'(byte_ready), 32'(!(start || error)));
    end
  end

  task automatic clear_log();
    log_cyc  = {};
    log_addr = {};
    log_data = {};
  endtask

  // Send a framed stream; the model predicts writes and the final outcome from the frame alone.
  task automatic send_stream(input logic [7:0] s[$], input int gap, input bit final_chk);
    int   cnt;
    int   c;
    bit   rdy;
    bit   exp_busy;
    logic [7:0] x;
    cnt = int'(s[0]) | (int'(s[1]) << 8);
    for (int p = 0; p < s.size(); p++) begin
      @(negedge clk);
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      byte_data  = s[p];
      byte_valid = 1'b1;
      c   = cyc;
      rdy = byte_ready;
      @(posedge clk);
      #1 byte_valid = 1'b0;
      check("byte_ready", 32'(rdy), 32'd1);
      if (!rdy) break;
      if (cnt <= CAP && p >= 2 && p < 2 + 4 * cnt && (p - 2) % 4 == 3) begin
        exp_q.push_back('{cyc: c + 1, addr: (p - 2) / 4,
                          data: {s[p], s[p-1], s[p-2], s[p-3]}});
      end
      exp_busy = !((p == 1 && cnt > CAP) || (p == 2 + 4 * cnt));
      check("busy", 32'(busy), 32'(exp_busy));
    end
    if (final_chk) begin
      @(negedge clk);
      #1;
      if (cnt > CAP) begin
        check("start", 32'(start), 32'd0);
        check("error", 32'(error), 32'd1);
        check("words_final", 32'(words_loaded), 32'd0);
      end else begin
        x = 8'h00;
        for (int i = 2; i < 2 + 4 * cnt; i++) x ^= s[i];
        check("start", 32'(start), 32'(s[2 + 4 * cnt] == x));
        check("error", 32'(error), 32'(s[2 + 4 * cnt] != x));
        check("words_final", 32'(words_loaded), 32'(cnt));
      end
      check("ready_end", 32'(byte_ready), 32'd0);
      check("busy_end", 32'(busy), 32'd0);
      check("writes_pending", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    check("reload_ready", 32'(byte_ready), 32'd1);
    check("reload_start", 32'(start), 32'd0);
    check("reload_error", 32'(error), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic make_prog(input int n, input bit bad, output logic [7:0] s[$]);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    s = {};
    s.push_back(8'(n));
    s.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      s.push_back(b);
    end
    s.push_back(bad ? (x ^ 8'($urandom_range(255, 1))) : x);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_wren"}, 32'(imem_wren), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_data"}, imem_data, 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic check_prog1_log();
    check("log_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("log_addr0", 32'(log_addr[0]), 32'd0);
      check("log_data0", log_data[0], 32'h0000_0013);
      check("log_addr1", 32'(log_addr[1]), 32'd1);
      check("log_data1", log_data[1], 32'h00A0_0093);
    end
  endtask

  logic [7:0] prog1[$];
  logic [7:0] s[$];

  initial begin
    prog1 = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h20};
    #3;
    check_reset_values("rst");
    @(negedge clk);
    #2 rst = 1'b1;

    // Reference program at full rate: literal writes, 4 cycles apart.
    clear_log();
    send_stream(prog1, 0, 1'b1);
    check_prog1_log();
    if (log_cyc.size() == 2) check("wr_spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd4);
    check("p1_start", 32'(start), 32'd1);
    do_reload();

    // Bad checksum, then recovery.
    s = prog1;
    s[s.size() - 1] = 8'h21;
    send_stream(s, 0, 1'b1);
    check("bad_error", 32'(error), 32'd1);
    do_reload();
    send_stream(prog1, 0, 1'b1);
    check("recover_start", 32'(start), 32'd1);
    do_reload();

    // Empty program.
    clear_log();
    send_stream('{8'h00, 8'h00, 8'h00}, 0, 1'b1);
    check("empty_start", 32'(start), 32'd1);
    check("empty_writes", 32'(log_addr.size()), 32'd0);
    do_reload();

    // Oversized header is rejected on its high byte.
    clear_log();
    send_stream('{8'h11, 8'h00}, 0, 1'b1);
    check("over_writes", 32'(log_addr.size()), 32'd0);
    do_reload();

    // Exactly full memory.
    clear_log();
    make_prog(CAP, 1'b0, s);
    send_stream(s, 0, 1'b1);
    check("full_count", 32'(log_addr.size()), 32'd16);
    if (log_addr.size() > 0) check("full_last_addr", 32'(log_addr[log_addr.size() - 1]), 32'd15);
    do_reload();

    // Reference program with random valid gaps.
    clear_log();
    send_stream(prog1, 3, 1'b1);
    check_prog1_log();
    do_reload();

    // Random programs, some with corrupted checksums.
    for (int t = 0; t < 8; t++) begin
      make_prog($urandom_range(CAP, 0), ($urandom_range(3, 0) == 0), s);
      send_stream(s, $urandom_range(3, 0), 1'b1);
      do_reload();
    end

    // Reset after 5 payload bytes, then a clean load.
    s = prog1[0:6];
    send_stream(s, 0, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q = {};
    @(negedge clk);
    #2 rst = 1'b1;
    clear_log();
    send_stream(prog1, 0, 1'b1);
    check_prog1_log();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader sitting directly upstream of the pipelined processor's instruction memory. It consumes a byte stream (from the UART receiver) framed as a 16-bit word count, a little-endian 32-bit instruction payload and an XOR checksum. It writes each assembled word into instruction memory through its write port. It asserts `start` to release the processor's fetch stage only after a complete, checksum-valid program has been stored.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `byte_data`  input  8  incoming stream byte.
- `byte_valid`  input  1  `byte_data` is valid.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `reload`  input  1  one-cycle pulse; restarts loading from DONE or ERROR.
- `imem_addr`  output  ADDR_WIDTH  instruction-memory word address.
- `imem_data`  output  32  instruction word to write.
- `imem_wren`  output  1  instruction-memory write enable, one-cycle pulse per word.
- `start`  output  1  program loaded and verified; drives the processor's fetch enable (`rden`).
- `busy`  output  1  a load is in progress (HDR_HI, PAYLOAD or CHECK).
- `error`  output  1  the load failed; sticky until `reload` or reset.
- `words_loaded`  output  16  number of words written in the current load.

## Operation
- A byte is accepted on a rising edge where `byte_valid && byte_ready`.
- `byte_ready` = 1 in HDR_LO, HDR_HI, PAYLOAD and CHECK; 0 in DONE and ERROR.
- FSM states and transitions:
  - **HDR_LO**: accept byte → `count[7:0]`; go to HDR_HI.
  - **HDR_HI**: accept byte → `count[15:8]`. Then:
    - full count > 2**ADDR_WIDTH → ERROR.
    - full count = 0 → CHECK.
    - otherwise → PAYLOAD.
  - **PAYLOAD**: bytes are packed little-endian. Byte k of a word goes to bits [8k+7:8k], k = 0..3.
    - Every payload byte is XORed into an 8-bit checksum accumulator; the accumulator is cleared on entry to HDR_LO.
    - On acceptance of byte 3, the word is written to address `words_loaded` and `words_loaded` increments.
    - When `words_loaded` reaches count → CHECK.
  - **CHECK**: accept one byte. Equal to the accumulator → DONE; otherwise → ERROR.
  - **DONE**: `start` = 1. A `reload` pulse → HDR_LO.
  - **ERROR**: `error` = 1, `start` = 0. A `reload` pulse → HDR_LO.
- `reload` is ignored in every other state.
- On entering HDR_LO, `words_loaded`, the checksum accumulator and the byte index are cleared.
- Memory contents are not erased on reload; words are simply overwritten.
- Header bytes and the checksum byte are never XORed into the accumulator.

## Timing
- Reset values (asynchronous on `rst` = 0):
  - state = HDR_LO, so `byte_ready` = 1.
  - `imem_wren` = 0, `imem_addr` = 0, `imem_data` = 0.
  - `start` = 0, `busy` = 0, `error` = 0, `words_loaded` = 0.
- Reset mid-load discards all progress. Partially written memory is left as is; `start` stays 0.
- `imem_wren`, `imem_addr` and `imem_data` are registered. They are valid for exactly one cycle, the cycle after the edge that accepted byte 3 of a word.
  - Back-to-back words at full byte rate produce at most one write pulse every 4 cycles.
  - The loader never stalls the byte stream.
- `words_loaded` updates on the same edge that raises `imem_wren`.
- `start` and `busy`/`error` are registered state decodes. `start` rises on the edge after the checksum byte is accepted and matches. It falls on the edge that accepts `reload`.
- ERROR is entered on the edge that accepts the offending byte (header high byte or checksum byte).
- Gaps in `byte_valid` stall progress with no other effect; there is no timeout.
- Count = 2**ADDR_WIDTH fills memory exactly. The last word's address is 2**ADDR_WIDTH−1 and no address wrap-around occurs.

## Test plan
- Program load, bytes `02 00 13 00 00 00 93 00 A0 00 20` at one byte per cycle:
  - wren at addr 0 with data 0x00000013, then at addr 1 with 0x00A00093, spaced 4 cycles apart.
  - `words_loaded` = 2, `start` = 1 one cycle after `20` is accepted; `error` = 0.
- Same program with checksum `21` → `error` = 1, `start` = 0, `byte_ready` = 0.
  - `reload` plus the correct stream → `start` = 1, `error` = 0.
- Empty program `00 00 00` → DONE with no `imem_wren` pulse, `words_loaded` = 0.
- `ADDR_WIDTH` = 4, header `11 00` (17 words) → ERROR immediately after byte 2; no write.
  - Header `10 00` followed by 16 words and a valid checksum → last write at addr 15.
- First scenario's stream with random 0–3 cycle `byte_valid` gaps → identical writes and result.
- `rst` pulsed low after 5 payload bytes → all outputs return to reset values immediately.
  - A fresh full stream then loads correctly.
